// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
//
// Purpose:
//   Sums each group of LEN consecutive unsigned products into an ACC_W-bit
//   result (dot product / multiply-accumulate). It sits downstream of the 4x4
//   shift-add multiplier. Products arrive over a valid/ready handshake.
//   Finished results leave over a second valid/ready handshake, each with an
//   overflow flag.
//
// Build option:
//   MAC_ACCUMULATOR_SATURATE_EN - when defined, a carry out of ACC_W clamps
//   the accumulator to all-ones for the rest of the group. When undefined
//   (default), the accumulator wraps modulo 2^ACC_W. Overflow is reported in
//   both builds. Handshake and timing are the same in both builds.
//
// Parameters:
//   PROD_W - product width (default 8)
//   ACC_W  - accumulator/result width, must be >= PROD_W (default 10)
//   LEN    - products per result, 1..255 (default 4)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous abort; drops the partial sum or pending result
//   prod_in    in   [PROD_W-1:0] unsigned product
//   prod_valid in   prod_in is valid
//   prod_ready out  block accepts prod_in this cycle
//   sum_out    out  [ACC_W-1:0] group result
//   sum_valid  out  sum_out/overflow are valid
//   sum_ready  in   downstream accepts sum_out
//   overflow   out  result exceeded 2^ACC_W-1
//   busy       out  at least one product of the current group accepted
// ---------------------------------------------------------------------------
module mac_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 10,
    parameter int LEN    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              overflow,
    output logic              busy
);

    // A 1-bit counter still works for LEN=1, where cnt stays at zero.
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int EXT_W = ACC_W + 1 - PROD_W;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [ACC_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               ovf_reg;
    logic [ACC_W-1:0]   sum_out_reg;
    logic               overflow_reg;

    logic               prod_fire;
    logic               sum_fire;
    logic               last_prod;
    logic [ACC_W:0]     add_full;
    logic               add_carry;
    logic [ACC_W-1:0]   acc_upd;

    // ------------------------------------------------------------------
    // Adder: zero-extended product plus accumulator. The extra top bit
    // carries the overflow out of ACC_W.
    // ------------------------------------------------------------------
    assign add_full  = {1'b0, acc_reg} + {{EXT_W{1'b0}}, prod_in};
    assign add_carry = add_full[ACC_W];

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    // A group stays clamped once it has overflowed, even if later adds
    // would not carry again (for example, adding zero).
    assign acc_upd = (add_carry || ovf_reg) ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
    assign acc_upd = add_full[ACC_W-1:0];
`endif

    assign prod_fire = prod_valid & prod_ready;
    assign sum_fire  = sum_valid & sum_ready;
    assign last_prod = (cnt_reg == CNT_W'(LEN - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_ACC;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. clear overrides every other transition.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ST_ACC;
        end else begin
            case (state_reg)
                ST_ACC: begin
                    if (prod_fire && last_prod) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A result can be consumed here, but a product cannot be
                    // accepted: prod_ready is low in DONE. This creates the
                    // one-cycle bubble.
                    if (sum_fire) begin
                        state_next = ST_ACC;
                    end
                end
                default: state_next = ST_ACC;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        prod_ready = 1'b0;
        sum_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            ST_ACC: begin
                prod_ready = 1'b1;
                busy       = (cnt_reg != '0);
            end
            ST_DONE: begin
                sum_valid = 1'b1;
            end
            default: begin
                prod_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg      <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            sum_out_reg  <= '0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            // A product offered alongside clear is dropped on purpose.
            acc_reg      <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (state_reg == ST_ACC) begin
            if (prod_fire) begin
                if (last_prod) begin
                    sum_out_reg  <= acc_upd;
                    overflow_reg <= ovf_reg | add_carry;
                    ovf_reg      <= ovf_reg | add_carry;
                    acc_reg      <= '0;
                    cnt_reg      <= '0;
                end else begin
                    acc_reg <= acc_upd;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    ovf_reg <= ovf_reg | add_carry;
                end
            end
        end else begin
            // DONE: the result is held until it is consumed. Then the
            // sticky flag is cleared so it is ready for the next group.
            if (sum_fire) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign sum_out  = sum_out_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

    localparam int AW = 9;   // instance A: ACC_W=9, LEN=4
    localparam int BW = 10;  // instance B: default ACC_W, LEN=1

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           a_clear, a_prod_valid, a_prod_ready, a_sum_valid, a_sum_ready;
    logic           a_overflow, a_busy;
    logic [7:0]     a_prod_in;
    logic [AW-1:0]  a_sum_out;
    logic           b_clear, b_prod_valid, b_prod_ready, b_sum_valid, b_sum_ready;
    logic           b_overflow, b_busy;
    logic [7:0]     b_prod_in;
    logic [BW-1:0]  b_sum_out;

    mac_accumulator #(.PROD_W(8), .ACC_W(AW), .LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear), .prod_in(a_prod_in),
        .prod_valid(a_prod_valid), .prod_ready(a_prod_ready), .sum_out(a_sum_out),
        .sum_valid(a_sum_valid), .sum_ready(a_sum_ready), .overflow(a_overflow),
        .busy(a_busy)
    );

    mac_accumulator #(.PROD_W(8), .ACC_W(BW), .LEN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .prod_in(b_prod_in),
        .prod_valid(b_prod_valid), .prod_ready(b_prod_ready), .sum_out(b_sum_out),
        .sum_valid(b_sum_valid), .sum_ready(b_sum_ready), .overflow(b_overflow),
        .busy(b_busy)
    );

    typedef struct packed {
        logic [AW-1:0] sum;
        logic          ovf;
    } exp_a_t;

    typedef struct packed {
        logic [BW-1:0] sum;
        logic          ovf;
    } exp_b_t;

    typedef struct packed {
        logic [3:0][7:0] p;
        logic [AW-1:0]   sum;
        logic            ovf;
    } vec_t;

    exp_a_t qa[$];
    exp_b_t qb[$];
    vec_t   vecs[8];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: compare each consumed result against the queue.
    always @(negedge clk) begin
        exp_a_t e;
        if (rst_n && a_sum_valid && a_sum_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result", 32'(a_sum_out), 32'hFFFF_FFFF);
            end else begin
                e = qa.pop_front();
                chk("a_sum_out", 32'(a_sum_out), 32'(e.sum));
                chk("a_overflow", 32'(a_overflow), 32'(e.ovf));
                $display("A result sum=%0d ovf=%0d (exp %0d/%0d)", a_sum_out, a_overflow, e.sum, e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        exp_b_t e;
        if (rst_n && b_sum_valid && b_sum_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result", 32'(b_sum_out), 32'hFFFF_FFFF);
            end else begin
                e = qb.pop_front();
                chk("b_sum_out", 32'(b_sum_out), 32'(e.sum));
                chk("b_overflow", 32'(b_overflow), 32'(e.ovf));
                $display("B result sum=%0d ovf=%0d (exp %0d/%0d)", b_sum_out, b_overflow, e.sum, e.ovf);
            end
        end
    end

    // Offer one product to A and return #1 after the edge that accepts it.
    task automatic send_a(input logic [7:0] v);
        int   n;
        logic rdy;
        a_prod_valid = 1'b1;
        a_prod_in    = v;
        n = 0;
        do begin
            @(negedge clk);
            rdy = a_prod_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("a_send_timeout", 32'(n), 32'(0));
        a_prod_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] v);
        int   n;
        logic rdy;
        b_prod_valid = 1'b1;
        b_prod_in    = v;
        n = 0;
        do begin
            @(negedge clk);
            rdy = b_prod_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("b_send_timeout", 32'(n), 32'(0));
        b_prod_valid = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        while (qa.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("a_drain_pending", 32'(qa.size()), 32'(0));
    endtask

    task automatic drain_b();
        int n = 0;
        while (qb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b_drain_pending", 32'(qb.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_cyc;
        logic [7:0] bv[3];

        // Table of groups: products and expected result/overflow at ACC_W=9.
        vecs[0] = '{p: {8'd60, 8'd45, 8'd30, 8'd15}, sum: 9'd150, ovf: 1'b0};
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        vecs[1] = '{p: {8'd225, 8'd225, 8'd225, 8'd225}, sum: 9'd511, ovf: 1'b1};
        vecs[5] = '{p: {8'd0, 8'd2, 8'd255, 8'd255}, sum: 9'd511, ovf: 1'b1};
        vecs[7] = '{p: {8'd200, 8'd200, 8'd200, 8'd200}, sum: 9'd511, ovf: 1'b1};
`else
        vecs[1] = '{p: {8'd225, 8'd225, 8'd225, 8'd225}, sum: 9'd388, ovf: 1'b1};
        vecs[5] = '{p: {8'd0, 8'd2, 8'd255, 8'd255}, sum: 9'd0, ovf: 1'b1};
        vecs[7] = '{p: {8'd200, 8'd200, 8'd200, 8'd200}, sum: 9'd288, ovf: 1'b1};
`endif
        vecs[2] = '{p: {8'd1, 8'd1, 8'd1, 8'd1}, sum: 9'd4, ovf: 1'b0};
        vecs[3] = '{p: {8'd150, 8'd50, 8'd200, 8'd100}, sum: 9'd500, ovf: 1'b0};
        vecs[4] = '{p: {8'd0, 8'd1, 8'd255, 8'd255}, sum: 9'd511, ovf: 1'b0};
        vecs[6] = '{p: {8'd127, 8'd128, 8'd128, 8'd128}, sum: 9'd511, ovf: 1'b0};

        rst_n = 1'b0;
        a_clear = 0; a_prod_valid = 0; a_prod_in = 0; a_sum_ready = 0;
        b_clear = 0; b_prod_valid = 0; b_prod_in = 0; b_sum_ready = 0;
        #1;
        chk("rst_prod_ready", 32'(a_prod_ready), 32'(1));
        chk("rst_sum_valid", 32'(a_sum_valid), 32'(0));
        chk("rst_busy", 32'(a_busy), 32'(0));
        chk("rst_sum_out", 32'(a_sum_out), 32'(0));
        chk("rst_overflow", 32'(a_overflow), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back group: latency and the bubble after consumption.
        a_sum_ready = 1'b1;
        qa.push_back('{sum: 9'd150, ovf: 1'b0});
        send_a(8'd15);
        send_a(8'd30);
        send_a(8'd45);
        chk("t1_busy_mid", 32'(a_busy), 32'(1));
        chk("t1_valid_early", 32'(a_sum_valid), 32'(0));
        send_a(8'd60);
        chk("t1_valid_latency", 32'(a_sum_valid), 32'(1));
        chk("t1_ready_done", 32'(a_prod_ready), 32'(0));
        chk("t1_busy_done", 32'(a_busy), 32'(0));
        @(posedge clk);
        #1;
        chk("t1_valid_consumed", 32'(a_sum_valid), 32'(0));
        chk("t1_ready_back", 32'(a_prod_ready), 32'(1));
        drain_a();

        // Table-driven groups.
        for (int i = 0; i < 8; i++) begin
            qa.push_back('{sum: vecs[i].sum, ovf: vecs[i].ovf});
            for (int k = 0; k < 4; k++) send_a(vecs[i].p[k]);
        end
        drain_a();

        // Downstream stall with the product still offered.
        a_sum_ready = 1'b0;
        qa.push_back('{sum: 9'd40, ovf: 1'b0});
        for (int k = 0; k < 4; k++) send_a(8'd10);
        a_prod_valid = 1'b1;
        a_prod_in    = 8'd10;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(a_sum_valid), 32'(1));
            chk("stall_sum", 32'(a_sum_out), 32'(40));
            chk("stall_ready", 32'(a_prod_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        a_sum_ready = 1'b1;
        @(negedge clk);
        chk("stall_ready_handshake", 32'(a_prod_ready), 32'(0));
        @(negedge clk);
        chk("stall_ready_after", 32'(a_prod_ready), 32'(1));
        @(posedge clk);
        #1;
        chk("stall_first_accepted", 32'(a_busy), 32'(1));
        a_prod_valid = 1'b0;
        qa.push_back('{sum: 9'd40, ovf: 1'b0});
        for (int k = 0; k < 3; k++) send_a(8'd10);
        drain_a();

        // clear mid-group drops the partial sum and the product offered with it.
        send_a(8'd100);
        send_a(8'd100);
        chk("clr_busy_before", 32'(a_busy), 32'(1));
        a_clear      = 1'b1;
        a_prod_valid = 1'b1;
        a_prod_in    = 8'd50;
        @(negedge clk);
        chk("clr_ready_kept", 32'(a_prod_ready), 32'(1));
        @(posedge clk);
        #1;
        a_clear      = 1'b0;
        a_prod_valid = 1'b0;
        chk("clr_busy_after", 32'(a_busy), 32'(0));
        qa.push_back('{sum: 9'd4, ovf: 1'b0});
        for (int k = 0; k < 4; k++) send_a(8'd1);
        drain_a();

        // clear in DONE discards the pending result.
        a_sum_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_a(8'd5);
        chk("clr_done_valid", 32'(a_sum_valid), 32'(1));
        a_clear = 1'b1;
        @(posedge clk);
        #1;
        a_clear = 1'b0;
        chk("clr_done_valid_gone", 32'(a_sum_valid), 32'(0));
        chk("clr_done_ready", 32'(a_prod_ready), 32'(1));
        chk("clr_done_overflow", 32'(a_overflow), 32'(0));
        a_sum_ready = 1'b1;

        // Asynchronous reset in the middle of a group.
        for (int k = 0; k < 3; k++) send_a(8'd20);
        chk("rst2_busy_before", 32'(a_busy), 32'(1));
        chk("rst2_sum_before", 32'(a_sum_out), 32'(20));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_prod_ready", 32'(a_prod_ready), 32'(1));
        chk("rst2_busy", 32'(a_busy), 32'(0));
        chk("rst2_sum_valid", 32'(a_sum_valid), 32'(0));
        chk("rst2_sum_out", 32'(a_sum_out), 32'(0));
        chk("rst2_overflow", 32'(a_overflow), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        qa.push_back('{sum: 9'd80, ovf: 1'b0});
        for (int k = 0; k < 4; k++) send_a(8'd20);
        drain_a();

        // LEN=1: each product is a result, with one bubble between accepts.
        b_sum_ready = 1'b1;
        bv[0] = 8'd255;
        bv[1] = 8'd0;
        bv[2] = 8'd7;
        last_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            qb.push_back('{sum: BW'(bv[i]), ovf: 1'b0});
            send_b(bv[i]);
            chk("b_valid_latency", 32'(b_sum_valid), 32'(1));
            chk("b_sum_direct", 32'(b_sum_out), 32'(bv[i]));
            if (i > 0) chk("b_accept_spacing", 32'(cyc - last_cyc), 32'(2));
            last_cyc = cyc;
        end
        drain_b();

        chk("a_queue_empty", 32'(qa.size()), 32'(0));
        chk("b_queue_empty", 32'(qb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
